// File: rtl/d_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// d_mem_arbiter_if
// Bundles the two requester handshakes and the d_mem bus seen by the arbiter.
//   Port 0 / Port 1 : Req, We, Addr, WData  (requester -> arbiter)
//                     Ack, Err, RData      (arbiter -> requester)
//   Memory side     : MemAddress, MemWriteData, MemWrite, MemRead (to d_mem)
//                     MemReadData (from d_mem)
//   Status          : Busy (arbiter not idle)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the d_mem instance)
// ---------------------------------------------------------------------------
interface d_mem_arbiter_if;
  logic        Req0;
  logic        We0;
  logic [31:0] Addr0;
  logic [31:0] WData0;
  logic        Ack0;
  logic        Err0;
  logic [31:0] RData0;

  logic        Req1;
  logic        We1;
  logic [31:0] Addr1;
  logic [31:0] WData1;
  logic        Ack1;
  logic        Err1;
  logic [31:0] RData1;

  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  logic        Busy;

  modport slave (
    input  Req0, We0, Addr0, WData0,
    input  Req1, We1, Addr1, WData1,
    input  MemReadData,
    output Ack0, Err0, RData0,
    output Ack1, Err1, RData1,
    output MemAddress, MemWriteData, MemWrite, MemRead,
    output Busy
  );

  modport master (
    output Req0, We0, Addr0, WData0,
    output Req1, We1, Addr1, WData1,
    output MemReadData,
    input  Ack0, Err0, RData0,
    input  Ack1, Err1, RData1,
    input  MemAddress, MemWriteData, MemWrite, MemRead,
    input  Busy
  );
endinterface

// File: rtl/d_mem_arbiter.sv
// ---------------------------------------------------------------------------
// d_mem_arbiter
// Shares one single-port data memory between two requesters with round-robin
// arbitration, address range checking and read-data capture. Every
// memory-side output is driven directly from a flop so the asynchronously
// writing d_mem never sees a glitch on MemWrite.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - d_mem_arbiter_if.slave (requester handshakes + d_mem bus + Busy)
// Parameter:
//   MemSize - log2 of memory depth in bytes; legal addresses 0..2^MemSize-4
// ---------------------------------------------------------------------------
module d_mem_arbiter #(
  parameter int MemSize = 6
) (
  input  logic            clock,
  input  logic            reset,
  d_mem_arbiter_if.slave  bus
);

  localparam logic [31:0] ADDR_MAX = 32'((1 << MemSize) - 4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;       // 0 = port 0, 1 = port 1
  logic        r_last_grant;
  logic        r_we;

  logic        w_any_req;
  logic        w_pick1;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_in_range;

  // Winner selection: port 1 wins when it is alone, or on a tie when port 0
  // was granted last.
  always_comb begin
    w_any_req  = bus.Req0 | bus.Req1;
    w_pick1    = bus.Req1 & (~bus.Req0 | ~r_last_grant);
    w_we       = w_pick1 ? bus.We1    : bus.We0;
    w_addr     = w_pick1 ? bus.Addr1  : bus.Addr0;
    w_wdata    = w_pick1 ? bus.WData1 : bus.WData0;
    w_in_range = (w_addr <= ADDR_MAX);
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; an out-of-range request skips ACCESS entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_in_range ? ST_ACCESS : ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs and grant bookkeeping. Outputs are loaded on the edge
  // that enters a state so they are valid for that whole state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant          <= 1'b0;
      r_last_grant     <= 1'b1;
      r_we             <= 1'b0;
      bus.Ack0         <= 1'b0;
      bus.Err0         <= 1'b0;
      bus.RData0       <= 32'd0;
      bus.Ack1         <= 1'b0;
      bus.Err1         <= 1'b0;
      bus.RData1       <= 32'd0;
      bus.MemAddress   <= 32'd0;
      bus.MemWriteData <= 32'd0;
      bus.MemWrite     <= 1'b0;
      bus.MemRead      <= 1'b0;
      bus.Busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_pick1;
            r_last_grant <= w_pick1;
            r_we         <= w_we;
            bus.Busy     <= 1'b1;
            if (w_in_range) begin
              bus.MemAddress <= w_addr;
              bus.MemWrite   <= w_we;
              bus.MemRead    <= ~w_we;
              if (w_we) begin
                bus.MemWriteData <= w_wdata;
              end
            end else if (w_pick1) begin
              // Error path: answer straight away, memory untouched.
              bus.Ack1   <= 1'b1;
              bus.Err1   <= 1'b1;
              bus.RData1 <= 32'd0;
            end else begin
              bus.Ack0   <= 1'b1;
              bus.Err0   <= 1'b1;
              bus.RData0 <= 32'd0;
            end
          end
        end
        ST_ACCESS: begin
          bus.MemWrite <= 1'b0;
          bus.MemRead  <= 1'b0;
          if (r_grant) begin
            bus.Ack1   <= 1'b1;
            bus.RData1 <= r_we ? 32'd0 : bus.MemReadData;
          end else begin
            bus.Ack0   <= 1'b1;
            bus.RData0 <= r_we ? 32'd0 : bus.MemReadData;
          end
        end
        ST_RESP: begin
          bus.Ack0 <= 1'b0;
          bus.Err0 <= 1'b0;
          bus.Ack1 <= 1'b0;
          bus.Err1 <= 1'b0;
          bus.Busy <= 1'b0;
        end
        default: begin
          bus.Ack0     <= 1'b0;
          bus.Err0     <= 1'b0;
          bus.Ack1     <= 1'b0;
          bus.Err1     <= 1'b0;
          bus.MemWrite <= 1'b0;
          bus.MemRead  <= 1'b0;
          bus.Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_d_mem_arbiter
// Directed self-checking bench for d_mem_arbiter with a 16-word memory model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_d_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  d_mem_arbiter_if bus();

  d_mem_arbiter #(.MemSize(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory model: preset to 0x1000_0000 + word index, written on clock edge.
  logic [31:0] mem [0:15];
  logic        mem_clear = 1'b1;
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h1000_0000 + 32'(k);
    end else if (bus.MemWrite) begin
      mem[bus.MemAddress[5:2]] <= bus.MemWriteData;
    end
  end
  assign bus.MemReadData = bus.MemRead ? mem[bus.MemAddress[5:2]] : 32'h0;

  // Activity monitor.
  int          mw_cnt = 0;
  int          acc_cnt = 0;
  int          ack0_cnt = 0;
  int          ack1_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] mw_addr_last = 32'h0;
  always @(negedge clock) begin
    if (bus.MemWrite) begin
      mw_cnt       <= mw_cnt + 1;
      mw_addr_last <= bus.MemAddress;
    end
    if (bus.MemWrite || bus.MemRead) acc_cnt <= acc_cnt + 1;
    if (bus.Ack0) ack0_cnt <= ack0_cnt + 1;
    if (bus.Ack1) ack1_cnt <= ack1_cnt + 1;
    if (bus.Ack0 && bus.Ack1) overlap_cnt <= overlap_cnt + 1;
  end

  // Single access on one port; lat = falling edges from request to Ack (-1 on timeout).
  task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
    @(negedge clock);
    if (port) begin
      bus.Req1 = 1'b1; bus.We1 = we; bus.Addr1 = addr; bus.WData1 = wdata;
    end else begin
      bus.Req0 = 1'b1; bus.We0 = we; bus.Addr0 = addr; bus.WData0 = wdata;
    end
    lat = -1; rdata = 32'h0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (port ? bus.Ack1 : bus.Ack0) begin
        lat   = n;
        rdata = port ? bus.RData1 : bus.RData0;
        err   = port ? bus.Err1 : bus.Err0;
        break;
      end
    end
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
  endtask

  // Both ports request together; each drops its Req once acknowledged.
  task automatic dual_access(input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                             input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                             output int lat0, output int lat1,
                             output logic [31:0] rd0, output logic [31:0] rd1);
    @(negedge clock);
    bus.Req0 = 1'b1; bus.We0 = we0; bus.Addr0 = a0; bus.WData0 = d0;
    bus.Req1 = 1'b1; bus.We1 = we1; bus.Addr1 = a1; bus.WData1 = d1;
    lat0 = -1; lat1 = -1; rd0 = 32'h0; rd1 = 32'h0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (bus.Ack0 && lat0 < 0) begin lat0 = n; rd0 = bus.RData0; bus.Req0 = 1'b0; end
      if (bus.Ack1 && lat1 < 0) begin lat1 = n; rd1 = bus.RData1; bus.Req1 = 1'b0; end
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [133:0] v;
    reset = 1'b1; mem_clear = 1'b1;
    repeat (3) @(negedge clock);
    v = {bus.Ack0, bus.Err0, bus.RData0, bus.Ack1, bus.Err1, bus.RData1,
         bus.MemAddress, bus.MemWriteData, bus.MemWrite, bus.MemRead};
    total++;
    if (v !== 134'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", v); end
    total++;
    if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    mem_clear = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (bus.Busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.Busy); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; int mw0;
    mw0 = mw_cnt;
    do_access(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF, rd, er, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    @(negedge clock); #1;
    total++;
    if (mw_cnt - mw0 !== 1) begin bad++; $display("FAIL wr_memwrite_cycles got=%0d exp=1", mw_cnt - mw0); end
    total++;
    if (mw_addr_last !== 32'd8) begin bad++; $display("FAIL wr_address got=%h exp=8", mw_addr_last); end
    total++;
    if (mem[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[2]); end
    do_access(1'b0, 1'b0, 32'd8, 32'h0, rd, er, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", er); end
  endtask

  task automatic test_simultaneous();
    int l0, l1, ov0; logic [31:0] r0, r1;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    ov0 = overlap_cnt;
    // Round 1: port 0 read 4, port 1 write 12 <- 5
    dual_access(1'b0, 32'd4, 32'h0, 1'b1, 32'd12, 32'h5, l0, l1, r0, r1);
    total++;
    if (l0 !== 2 || l1 !== 5) begin bad++; $display("FAIL sim1_order got=%0d/%0d exp=2/5", l0, l1); end
    total++;
    if (r0 !== 32'h1000_0001) begin bad++; $display("FAIL sim1_rdata0 got=%h exp=10000001", r0); end
    total++;
    if (mem[3] !== 32'h5) begin bad++; $display("FAIL sim1_mem got=%h exp=5", mem[3]); end
    // Round 2: port 0 write 16 <- 0xA, port 1 read 12
    dual_access(1'b1, 32'd16, 32'hA, 1'b0, 32'd12, 32'h0, l0, l1, r0, r1);
    total++;
    if (l0 !== 2 || l1 !== 5) begin bad++; $display("FAIL sim2_order got=%0d/%0d exp=2/5", l0, l1); end
    total++;
    if (r1 !== 32'h5) begin bad++; $display("FAIL sim2_rdata1 got=%h exp=5", r1); end
    // Round 3: both read; port 0 must lead again
    dual_access(1'b0, 32'd16, 32'h0, 1'b0, 32'd4, 32'h0, l0, l1, r0, r1);
    total++;
    if (l0 !== 2 || l1 !== 5) begin bad++; $display("FAIL sim3_order got=%0d/%0d exp=2/5", l0, l1); end
    total++;
    if (r0 !== 32'hA || r1 !== 32'h1000_0001) begin
      bad++; $display("FAIL sim3_rdata got=%h/%h exp=a/10000001", r0, r1);
    end
    @(negedge clock); #1;
    total++;
    if (overlap_cnt !== ov0) begin bad++; $display("FAIL sim_ack_overlap got=%0d exp=0", overlap_cnt - ov0); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; int mw0, a00;
    mw0 = mw_cnt; a00 = ack0_cnt;
    do_access(1'b1, 1'b1, 32'd61, 32'h77, rd, er, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL oor_latency got=%0d exp=1", lat); end
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", er); end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", rd); end
    @(negedge clock); #1;
    total++;
    if (mw_cnt !== mw0 || ack0_cnt !== a00) begin
      bad++; $display("FAIL oor_side_effects got=mw%0d/ack0_%0d exp=0/0", mw_cnt - mw0, ack0_cnt - a00);
    end
    total++;
    if (mem[15] !== 32'h1000_000F) begin bad++; $display("FAIL oor_mem got=%h exp=1000000f", mem[15]); end
    // Highest legal address
    do_access(1'b0, 1'b0, 32'd60, 32'h0, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h1000_000F) begin
      bad++; $display("FAIL edge_addr60 got=lat%0d err%b %h exp=lat2 err0 1000000f", lat, er, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    @(negedge clock);
    bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 32'd20; bus.WData0 = 32'h99;
    @(posedge clock); #1;
    total++;
    if (bus.MemWrite !== 1'b1) begin bad++; $display("FAIL mid_access_memwrite got=%b exp=1", bus.MemWrite); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.MemWrite !== 1'b0 || bus.Busy !== 1'b0 || bus.Ack0 !== 1'b0) begin
      bad++; $display("FAIL mid_reset_drop got=mw%b busy%b ack%b exp=000", bus.MemWrite, bus.Busy, bus.Ack0);
    end
    bus.Req0 = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    total++;
    if (mem[5] !== 32'h1000_0005) begin bad++; $display("FAIL mid_reset_mem got=%h exp=10000005", mem[5]); end
    do_access(1'b1, 1'b0, 32'd20, 32'h0, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h1000_0005) begin
      bad++; $display("FAIL mid_reset_recover got=lat%0d err%b %h exp=lat2 err0 10000005", lat, er, rd);
    end
  endtask

  task automatic test_held();
    int pos [0:3]; int cnt; int acc0;
    cnt = 0; acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) pos[i] = -1;
    @(negedge clock);
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 32'd8;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clock);
      if (bus.Ack0) begin
        if (cnt < 4) pos[cnt] = n;
        cnt++;
      end
      if (n == 9) bus.Req0 = 1'b0;
    end
    #1;
    total++;
    if (cnt !== 3) begin bad++; $display("FAIL held_ack_count got=%0d exp=3", cnt); end
    total++;
    if (pos[0] !== 2 || pos[1] !== 5 || pos[2] !== 8) begin
      bad++; $display("FAIL held_ack_spacing got=%0d,%0d,%0d exp=2,5,8", pos[0], pos[1], pos[2]);
    end
    total++;
    if (acc_cnt - acc0 !== 3) begin bad++; $display("FAIL held_accesses got=%0d exp=3", acc_cnt - acc0); end
    total++;
    if (bus.RData0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL held_rdata got=%h exp=deadbeef", bus.RData0); end
  endtask

  task automatic test_withdrawn();
    int a10, mw0, acc0, lat;
    a10 = ack1_cnt; mw0 = mw_cnt; acc0 = acc_cnt; lat = -1;
    @(negedge clock);
    bus.Req1 = 1'b1; bus.We1 = 1'b1; bus.Addr1 = 32'd24; bus.WData1 = 32'h42;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (n == 1) bus.Req1 = 1'b0;
      if (bus.Ack1 && lat < 0) lat = n;
    end
    #1;
    total++;
    if (ack1_cnt - a10 !== 1 || lat !== 2) begin
      bad++; $display("FAIL wd_ack got=cnt%0d lat%0d exp=cnt1 lat2", ack1_cnt - a10, lat);
    end
    total++;
    if (mw_cnt - mw0 !== 1 || acc_cnt - acc0 !== 1) begin
      bad++; $display("FAIL wd_accesses got=mw%0d acc%0d exp=1/1", mw_cnt - mw0, acc_cnt - acc0);
    end
    total++;
    if (mem[6] !== 32'h42) begin bad++; $display("FAIL wd_mem got=%h exp=42", mem[6]); end
  endtask

  initial begin
    bus.Req0 = 1'b0; bus.We0 = 1'b0; bus.Addr0 = 32'h0; bus.WData0 = 32'h0;
    bus.Req1 = 1'b0; bus.We1 = 1'b0; bus.Addr1 = 32'h0; bus.WData1 = 32'h0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid();
    test_held();
    test_withdrawn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
